// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: operation codes, result-type
// selects, bus widths and the divider state encoding.
package ex_pkg;

   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;
   localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;

   localparam logic [7:0] AluOpNop   = 8'b0000_0000;
   localparam logic [7:0] AluOpAnd   = 8'b0010_0100;
   localparam logic [7:0] AluOpOr    = 8'b0010_0101;
   localparam logic [7:0] AluOpXor   = 8'b0010_0110;
   localparam logic [7:0] AluOpNor   = 8'b0010_0111;
   localparam logic [7:0] AluOpSll   = 8'b0111_1100;
   localparam logic [7:0] AluOpSrl   = 8'b0000_0010;
   localparam logic [7:0] AluOpSra   = 8'b0000_0011;
   localparam logic [7:0] AluOpSlt   = 8'b0010_1010;
   localparam logic [7:0] AluOpSltu  = 8'b0010_1011;
   localparam logic [7:0] AluOpAdd   = 8'b0010_0000;
   localparam logic [7:0] AluOpAddu  = 8'b0010_0001;
   localparam logic [7:0] AluOpSub   = 8'b0010_0010;
   localparam logic [7:0] AluOpSubu  = 8'b0010_0011;
   localparam logic [7:0] AluOpMult  = 8'b0001_1000;
   localparam logic [7:0] AluOpMultu = 8'b0001_1001;
   localparam logic [7:0] AluOpDiv   = 8'b0001_1010;
   localparam logic [7:0] AluOpDivu  = 8'b0001_1011;
   localparam logic [7:0] AluOpMfhi  = 8'b0001_0000;
   localparam logic [7:0] AluOpMthi  = 8'b0001_0001;
   localparam logic [7:0] AluOpMflo  = 8'b0001_0010;
   localparam logic [7:0] AluOpMtlo  = 8'b0001_0011;

   localparam logic [2:0] AluSelNop   = 3'b000;
   localparam logic [2:0] AluSelLogic = 3'b001;
   localparam logic [2:0] AluSelShift = 3'b010;
   localparam logic [2:0] AluSelMove  = 3'b011;
   localparam logic [2:0] AluSelArith = 3'b100;

   typedef enum logic [1:0] {
      DivIdle = 2'b00,
      DivZero = 2'b01,
      DivOn   = 2'b10,
      DivEnd  = 2'b11
   } divState_e;

   // Two's-complement negate when doNeg is set, pass-through otherwise.
   function automatic logic [RegBus-1:0] negIf(input logic doNeg, input logic [RegBus-1:0] value);
      return doNeg ? (~value + 32'd1) : value;
   endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider. Operands are captured as magnitudes
// when a divide leaves IDLE, one quotient bit is produced per cycle, and the
// signs are re-applied on the way out. result_o = {remainder, quotient}.
module div
   import ex_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              signed_div_i,
   input  logic [RegBus-1:0] opdata1_i,
   input  logic [RegBus-1:0] opdata2_i,
   input  logic              start_i,
   output logic [63:0]       result_o,
   output logic              ready_o
);

   divState_e         r_state;
   divState_e         w_nextState;
   logic [4:0]        r_count;
   logic [RegBus-1:0] r_rem;
   logic [RegBus-1:0] r_quo;
   logic [RegBus-1:0] r_divisor;
   logic              r_negQuo;
   logic              r_negRem;

   logic              w_op1Neg;
   logic              w_op2Neg;
   logic [RegBus-1:0] w_op1Mag;
   logic [RegBus-1:0] w_op2Mag;
   logic [RegBus:0]   w_shifted;
   logic [RegBus:0]   w_diff;
   logic              w_fits;
   logic [RegBus-1:0] w_stepRem;
   logic [RegBus-1:0] w_stepQuo;

   assign w_op1Neg = signed_div_i & opdata1_i[RegBus-1];
   assign w_op2Neg = signed_div_i & opdata2_i[RegBus-1];
   assign w_op1Mag = negIf(w_op1Neg, opdata1_i);
   assign w_op2Mag = negIf(w_op2Neg, opdata2_i);

   // The partial remainder is always below the divisor, so shifting in the
   // next dividend bit needs one extra bit; a clear borrow means it fits.
   assign w_shifted = {r_rem, r_quo[RegBus-1]};
   assign w_diff    = w_shifted - {1'b0, r_divisor};
   assign w_fits    = ~w_diff[RegBus];
   assign w_stepRem = w_fits ? w_diff[RegBus-1:0] : w_shifted[RegBus-1:0];
   assign w_stepQuo = {r_quo[RegBus-2:0], w_fits};

   assign result_o = {negIf(r_negRem, r_rem), negIf(r_negQuo, r_quo)};
   assign ready_o  = (r_state == DivEnd);

   // State register for the divide sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= DivIdle;
      else     r_state <= w_nextState;
   end

   // Next-state logic: zero divisors short-cut through DIVZERO, everything
   // else spends exactly 32 cycles in ON before presenting the result.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         DivIdle: if (start_i) w_nextState = (opdata2_i == ZeroWord) ? DivZero : DivOn;
         DivZero: w_nextState = DivEnd;
         DivOn:   if (r_count == 5'd31) w_nextState = DivEnd;
         DivEnd:  w_nextState = DivIdle;
         default: w_nextState = DivIdle;
      endcase
   end

   // Operand capture and the per-cycle restoring step; inputs are only
   // looked at while IDLE so the ID stage may change them mid-divide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count   <= 5'd0;
         r_rem     <= ZeroWord;
         r_quo     <= ZeroWord;
         r_divisor <= ZeroWord;
         r_negQuo  <= 1'b0;
         r_negRem  <= 1'b0;
      end else begin
         case (r_state)
            DivIdle: begin
               if (start_i) begin
                  r_count   <= 5'd0;
                  r_rem     <= ZeroWord;
                  r_quo     <= w_op1Mag;
                  r_divisor <= w_op2Mag;
                  r_negQuo  <= w_op1Neg ^ w_op2Neg;
                  r_negRem  <= w_op1Neg;
               end
            end
            DivZero: begin
               r_rem <= ZeroWord;
               r_quo <= ZeroWord;
            end
            DivOn: begin
               r_rem   <= w_stepRem;
               r_quo   <= w_stepQuo;
               r_count <= r_count + 5'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ex.sv
// Execute stage: combinational logic/shift/arithmetic/move/multiply datapath
// with HI/LO forwarding from MEM, plus the iterative divider for DIV/DIVU.
module ex
   import ex_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            aluop_i,
   input  logic [2:0]            alusel_i,
   input  logic [RegBus-1:0]     reg1_i,
   input  logic [RegBus-1:0]     reg2_i,
   input  logic [RegAddrBus-1:0] wd_i,
   input  logic                  wreg_i,
   input  logic [RegBus-1:0]     hi_i,
   input  logic [RegBus-1:0]     lo_i,
   input  logic                  mem_whilo_i,
   input  logic [RegBus-1:0]     mem_hi_i,
   input  logic [RegBus-1:0]     mem_lo_i,
   output logic [RegAddrBus-1:0] wd_o,
   output logic                  wreg_o,
   output logic [RegBus-1:0]     wdata_o,
   output logic                  whilo_o,
   output logic [RegBus-1:0]     hi_o,
   output logic [RegBus-1:0]     lo_o,
   output logic                  stallreq_from_ex
);

   logic [RegBus-1:0] w_effHi;
   logic [RegBus-1:0] w_effLo;
   logic [RegBus-1:0] w_sum;
   logic [RegBus-1:0] w_diff;
   logic              w_addOvf;
   logic              w_subOvf;
   logic [63:0]       w_prodSigned;
   logic [63:0]       w_prodUnsigned;
   logic [RegBus-1:0] w_logicRes;
   logic [RegBus-1:0] w_shiftRes;
   logic [RegBus-1:0] w_arithRes;
   logic [RegBus-1:0] w_moveRes;
   logic              w_isDiv;
   logic [63:0]       w_divResult;
   logic              w_divReady;

   assign w_effHi = mem_whilo_i ? mem_hi_i : hi_i;
   assign w_effLo = mem_whilo_i ? mem_lo_i : lo_i;

   assign w_sum    = reg1_i + reg2_i;
   assign w_diff   = reg1_i - reg2_i;
   assign w_addOvf = (reg1_i[31] == reg2_i[31]) && (w_sum[31] != reg1_i[31]);
   assign w_subOvf = (reg1_i[31] != reg2_i[31]) && (w_diff[31] != reg1_i[31]);

   assign w_prodSigned   = $signed({{32{reg1_i[31]}}, reg1_i}) * $signed({{32{reg2_i[31]}}, reg2_i});
   assign w_prodUnsigned = {32'd0, reg1_i} * {32'd0, reg2_i};

   assign w_isDiv = (aluop_i == AluOpDiv) || (aluop_i == AluOpDivu);

   div u_div (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (aluop_i == AluOpDiv),
      .opdata1_i    (reg1_i),
      .opdata2_i    (reg2_i),
      .start_i      (w_isDiv),
      .result_o     (w_divResult),
      .ready_o      (w_divReady)
   );

   // Bitwise logic results.
   always_comb begin
      w_logicRes = ZeroWord;
      case (aluop_i)
         AluOpOr:  w_logicRes = reg1_i | reg2_i;
         AluOpAnd: w_logicRes = reg1_i & reg2_i;
         AluOpXor: w_logicRes = reg1_i ^ reg2_i;
         AluOpNor: w_logicRes = ~(reg1_i | reg2_i);
         default:  w_logicRes = ZeroWord;
      endcase
   end

   // Shifts take their amount from the low five bits of reg1.
   always_comb begin
      w_shiftRes = ZeroWord;
      case (aluop_i)
         AluOpSll: w_shiftRes = reg2_i << reg1_i[4:0];
         AluOpSrl: w_shiftRes = reg2_i >> reg1_i[4:0];
         AluOpSra: w_shiftRes = $signed(reg2_i) >>> reg1_i[4:0];
         default:  w_shiftRes = ZeroWord;
      endcase
   end

   // Add/subtract and set-less-than results; overflow is handled separately.
   always_comb begin
      w_arithRes = ZeroWord;
      case (aluop_i)
         AluOpAdd, AluOpAddu: w_arithRes = w_sum;
         AluOpSub, AluOpSubu: w_arithRes = w_diff;
         AluOpSlt:  w_arithRes = {31'd0, ($signed(reg1_i) < $signed(reg2_i))};
         AluOpSltu: w_arithRes = {31'd0, (reg1_i < reg2_i)};
         default:   w_arithRes = ZeroWord;
      endcase
   end

   // Reads of HI/LO see a pending MEM write before the committed value.
   always_comb begin
      w_moveRes = ZeroWord;
      case (aluop_i)
         AluOpMfhi: w_moveRes = w_effHi;
         AluOpMflo: w_moveRes = w_effLo;
         default:   w_moveRes = ZeroWord;
      endcase
   end

   // Final output steering: everything is held at zero during reset, the
   // register write is dropped on signed overflow or multiply, and divides
   // stall until the divider reports ready.
   always_comb begin
      wd_o             = '0;
      wreg_o           = 1'b0;
      wdata_o          = ZeroWord;
      whilo_o          = 1'b0;
      hi_o             = ZeroWord;
      lo_o             = ZeroWord;
      stallreq_from_ex = 1'b0;
      if (!rst) begin
         wd_o   = wd_i;
         wreg_o = wreg_i;
         case (alusel_i)
            AluSelLogic: wdata_o = w_logicRes;
            AluSelShift: wdata_o = w_shiftRes;
            AluSelArith: wdata_o = w_arithRes;
            AluSelMove:  wdata_o = w_moveRes;
            default:     wdata_o = ZeroWord;
         endcase
         if (((aluop_i == AluOpAdd) && w_addOvf) || ((aluop_i == AluOpSub) && w_subOvf) ||
             (aluop_i == AluOpMult) || (aluop_i == AluOpMultu)) begin
            wreg_o = 1'b0;
         end
         case (aluop_i)
            AluOpMult: begin
               whilo_o = 1'b1;
               hi_o    = w_prodSigned[63:32];
               lo_o    = w_prodSigned[31:0];
            end
            AluOpMultu: begin
               whilo_o = 1'b1;
               hi_o    = w_prodUnsigned[63:32];
               lo_o    = w_prodUnsigned[31:0];
            end
            AluOpDiv, AluOpDivu: begin
               stallreq_from_ex = ~w_divReady;
               if (w_divReady) begin
                  whilo_o = 1'b1;
                  hi_o    = w_divResult[63:32];
                  lo_o    = w_divResult[31:0];
               end
            end
            AluOpMthi: begin
               whilo_o = 1'b1;
               hi_o    = reg1_i;
               lo_o    = w_effLo;
            end
            AluOpMtlo: begin
               whilo_o = 1'b1;
               hi_o    = w_effHi;
               lo_o    = reg1_i;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex.sv
// Self-checking bench for the execute stage: a directed vector table, random
// single-cycle ops against a behavioural model, and hand-written divide,
// back-to-back and reset-abort sequences.
module tb_ex;
   import ex_pkg::*;

   logic        clk;
   logic        rst;
   logic [7:0]  aluop_i;
   logic [2:0]  alusel_i;
   logic [31:0] reg1_i, reg2_i, hi_i, lo_i, mem_hi_i, mem_lo_i;
   logic [4:0]  wd_i;
   logic        wreg_i, mem_whilo_i;
   logic [4:0]  wd_o;
   logic        wreg_o, whilo_o, stallreq_from_ex;
   logic [31:0] wdata_o, hi_o, lo_o;

   int testsRun;
   int testsFailed;

   typedef struct {
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] reg1, reg2, hi, lo;
      logic        memWhilo;
      logic [31:0] memHi, memLo;
      logic        wreg;
      logic [31:0] expWdata;
      logic        expWreg, expWhilo;
      logic [31:0] expHi, expLo;
   } vec_t;

   vec_t vectors[22];

   ex dut (
      .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
      .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
      .hi_i(hi_i), .lo_i(lo_i), .mem_whilo_i(mem_whilo_i),
      .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
      .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
      .hi_o(hi_o), .lo_o(lo_o), .stallreq_from_ex(stallreq_from_ex)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic vec_t mkVec(logic [7:0] op, logic [2:0] sel, logic [31:0] r1, logic [31:0] r2,
                                  logic [31:0] hi, logic [31:0] lo, logic mw, logic [31:0] mh,
                                  logic [31:0] ml, logic wr, logic [31:0] eWd, logic eWr,
                                  logic eWh, logic [31:0] eHi, logic [31:0] eLo);
      vec_t v;
      v.aluop = op; v.alusel = sel; v.reg1 = r1; v.reg2 = r2; v.hi = hi; v.lo = lo;
      v.memWhilo = mw; v.memHi = mh; v.memLo = ml; v.wreg = wr;
      v.expWdata = eWd; v.expWreg = eWr; v.expWhilo = eWh; v.expHi = eHi; v.expLo = eLo;
      return v;
   endfunction

   function automatic logic [2:0] selFor(logic [7:0] op);
      case (op)
         AluOpOr, AluOpAnd, AluOpXor, AluOpNor:                         return AluSelLogic;
         AluOpSll, AluOpSrl, AluOpSra:                                  return AluSelShift;
         AluOpSlt, AluOpSltu, AluOpAdd, AluOpAddu, AluOpSub, AluOpSubu: return AluSelArith;
         AluOpMfhi, AluOpMflo:                                          return AluSelMove;
         default:                                                       return AluSelNop;
      endcase
   endfunction

   // Behavioural reference for the single-cycle operations, in plain arithmetic.
   function automatic vec_t refModel(logic [7:0] op, logic [31:0] r1, logic [31:0] r2,
                                     logic [31:0] hi, logic [31:0] lo, logic mw,
                                     logic [31:0] mh, logic [31:0] ml, logic wr);
      vec_t v;
      longint s, a, b, p, q;
      logic [63:0] u;
      logic [31:0] effHi, effLo;
      int n;
      v = mkVec(op, selFor(op), r1, r2, hi, lo, mw, mh, ml, wr, 32'd0, wr, 1'b0, 32'd0, 32'd0);
      effHi = mw ? mh : hi;
      effLo = mw ? ml : lo;
      a = longint'(int'(r1));
      b = longint'(int'(r2));
      n = int'(r1 % 32);
      p = longint'(1) << n;
      case (op)
         AluOpOr:   v.expWdata = r1 | r2;
         AluOpAnd:  v.expWdata = r1 & r2;
         AluOpXor:  v.expWdata = r1 ^ r2;
         AluOpNor:  v.expWdata = ~(r1 | r2);
         AluOpSll:  begin u = {32'd0, r2} * 64'(p); v.expWdata = u[31:0]; end
         AluOpSrl:  begin u = {32'd0, r2} / 64'(p); v.expWdata = u[31:0]; end
         AluOpSra:  begin
            if (b >= 0) q = b / p;
            else        q = -((-b + p - 1) / p);
            v.expWdata = q[31:0];
         end
         AluOpAdd, AluOpSub: begin
            s = (op == AluOpAdd) ? a + b : a - b;
            v.expWdata = s[31:0];
            if (s > 64'sd2147483647 || s < -64'sd2147483648) v.expWreg = 1'b0;
         end
         AluOpAddu: begin u = {32'd0, r1} + {32'd0, r2}; v.expWdata = u[31:0]; end
         AluOpSubu: begin u = {32'd0, r1} + 64'h1_0000_0000 - {32'd0, r2}; v.expWdata = u[31:0]; end
         AluOpSlt:  v.expWdata = (a < b) ? 32'd1 : 32'd0;
         AluOpSltu: v.expWdata = (longint'(r1) < longint'(r2)) ? 32'd1 : 32'd0;
         AluOpMult: begin
            q = a * b;
            v.expWreg = 1'b0; v.expWhilo = 1'b1; v.expHi = q[63:32]; v.expLo = q[31:0];
         end
         AluOpMultu: begin
            u = {32'd0, r1} * {32'd0, r2};
            v.expWreg = 1'b0; v.expWhilo = 1'b1; v.expHi = u[63:32]; v.expLo = u[31:0];
         end
         AluOpMfhi: v.expWdata = effHi;
         AluOpMflo: v.expWdata = effLo;
         AluOpMthi: begin v.expWhilo = 1'b1; v.expHi = r1; v.expLo = effLo; end
         AluOpMtlo: begin v.expWhilo = 1'b1; v.expHi = effHi; v.expLo = r1; end
         default: ;
      endcase
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input logic [4:0] wd);
      aluop_i = v.aluop; alusel_i = v.alusel; reg1_i = v.reg1; reg2_i = v.reg2;
      hi_i = v.hi; lo_i = v.lo; mem_whilo_i = v.memWhilo; mem_hi_i = v.memHi;
      mem_lo_i = v.memLo; wreg_i = v.wreg; wd_i = wd;
   endtask

   task automatic runVector(input string tag, input vec_t v);
      logic [4:0] wd;
      wd = 5'($urandom_range(0, 31));
      @(posedge clk); #1;
      applyStimulus(v, wd);
      @(negedge clk);
      checkOutput({tag, " wdata"}, 64'(wdata_o), 64'(v.expWdata));
      checkOutput({tag, " wreg"},  64'(wreg_o),  64'(v.expWreg));
      checkOutput({tag, " whilo"}, 64'(whilo_o), 64'(v.expWhilo));
      checkOutput({tag, " hi"},    64'(hi_o),    64'(v.expHi));
      checkOutput({tag, " lo"},    64'(lo_o),    64'(v.expLo));
      checkOutput({tag, " wd"},    64'(wd_o),    64'(wd));
      checkOutput({tag, " stall"}, 64'(stallreq_from_ex), 64'd0);
   endtask

   // Runs one divide from IDLE, counting stall cycles and checking the result.
   task automatic runDivide(input string tag, input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] b, input bit scramble);
      longint q, r;
      int stalls, expStalls;
      bit done, sawWhilo;
      if (b == 32'd0) begin q = 0; r = 0; end
      else if (op == AluOpDiv) begin
         q = longint'(int'(a)) / longint'(int'(b));
         r = longint'(int'(a)) % longint'(int'(b));
      end else begin
         q = longint'(a) / longint'(b);
         r = longint'(a) % longint'(b);
      end
      expStalls = (b == 32'd0) ? 2 : 33;
      @(posedge clk); #1;
      aluop_i = op; alusel_i = AluSelNop; reg1_i = a; reg2_i = b;
      wreg_i = 1'b0; mem_whilo_i = 1'b0;
      stalls = 0; done = 0; sawWhilo = 0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         if (stallreq_from_ex) begin
            stalls++;
            if (whilo_o) sawWhilo = 1;
            @(posedge clk); #1;
            if (scramble) begin reg1_i = $urandom; reg2_i = $urandom; end
         end else begin
            done = 1;
         end
      end
      checkOutput({tag, " completed"}, 64'(done), 64'd1);
      checkOutput({tag, " stall cycles"}, 64'(stalls), 64'(expStalls));
      checkOutput({tag, " whilo during stall"}, 64'(sawWhilo), 64'd0);
      checkOutput({tag, " whilo"}, 64'(whilo_o), 64'd1);
      checkOutput({tag, " hi"}, 64'(hi_o), 64'(r[31:0]));
      checkOutput({tag, " lo"}, 64'(lo_o), 64'(q[31:0]));
   endtask

   logic [7:0] opList[20];

   function automatic logic [31:0] pickOperand();
      logic [31:0] specials[5];
      specials[0] = 32'h0; specials[1] = 32'h1; specials[2] = 32'h7FFF_FFFF;
      specials[3] = 32'h8000_0000; specials[4] = 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   initial begin
      bit sawStall, sawWhilo;
      vec_t v;
      testsRun = 0;
      testsFailed = 0;

      vectors[0]  = mkVec(AluOpOr,   AluSelLogic, 32'h0F0F0000, 32'h00000F0F, 0, 0, 0, 0, 0, 1, 32'h0F0F0F0F, 1, 0, 0, 0);
      vectors[1]  = mkVec(AluOpAnd,  AluSelLogic, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0, 0, 0, 1, 32'h0F000F00, 1, 0, 0, 0);
      vectors[2]  = mkVec(AluOpXor,  AluSelLogic, 32'hAAAA5555, 32'hFFFF0000, 0, 0, 0, 0, 0, 1, 32'h55555555, 1, 0, 0, 0);
      vectors[3]  = mkVec(AluOpNor,  AluSelLogic, 32'h0F0F0000, 32'h00000F0F, 0, 0, 0, 0, 0, 1, 32'hF0F0F0F0, 1, 0, 0, 0);
      vectors[4]  = mkVec(AluOpSra,  AluSelShift, 32'd4,        32'h80000000, 0, 0, 0, 0, 0, 1, 32'hF8000000, 1, 0, 0, 0);
      vectors[5]  = mkVec(AluOpSll,  AluSelShift, 32'd0,        32'h12345678, 0, 0, 0, 0, 0, 1, 32'h12345678, 1, 0, 0, 0);
      vectors[6]  = mkVec(AluOpSrl,  AluSelShift, 32'd31,       32'h80000000, 0, 0, 0, 0, 0, 1, 32'h00000001, 1, 0, 0, 0);
      vectors[7]  = mkVec(AluOpSll,  AluSelShift, 32'h24,       32'h00000001, 0, 0, 0, 0, 0, 1, 32'h00000010, 1, 0, 0, 0);
      vectors[8]  = mkVec(AluOpAdd,  AluSelArith, 32'h7FFFFFFF, 32'h00000001, 0, 0, 0, 0, 0, 1, 32'h80000000, 0, 0, 0, 0);
      vectors[9]  = mkVec(AluOpAddu, AluSelArith, 32'h7FFFFFFF, 32'h00000001, 0, 0, 0, 0, 0, 1, 32'h80000000, 1, 0, 0, 0);
      vectors[10] = mkVec(AluOpSub,  AluSelArith, 32'h80000000, 32'h00000001, 0, 0, 0, 0, 0, 1, 32'h7FFFFFFF, 0, 0, 0, 0);
      vectors[11] = mkVec(AluOpSubu, AluSelArith, 32'h00000000, 32'h00000001, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 1, 0, 0, 0);
      vectors[12] = mkVec(AluOpSlt,  AluSelArith, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 0, 0, 1, 32'h00000001, 1, 0, 0, 0);
      vectors[13] = mkVec(AluOpSltu, AluSelArith, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 0, 0, 1, 32'h00000000, 1, 0, 0, 0);
      vectors[14] = mkVec(AluOpMult, AluSelNop,   32'hFFFFFFFF, 32'h00000002, 0, 0, 0, 0, 0, 1, 32'h0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFE);
      vectors[15] = mkVec(AluOpMultu,AluSelNop,   32'hFFFFFFFF, 32'h00000002, 0, 0, 0, 0, 0, 1, 32'h0, 0, 1, 32'h00000001, 32'hFFFFFFFE);
      vectors[16] = mkVec(AluOpMfhi, AluSelMove,  32'h0, 32'h0, 32'hDEAD, 32'h0, 1, 32'h1234, 32'h5678, 1, 32'h1234, 1, 0, 0, 0);
      vectors[17] = mkVec(AluOpMflo, AluSelMove,  32'h0, 32'h0, 32'h0, 32'hBEEF, 0, 32'h1111, 32'h2222, 1, 32'hBEEF, 1, 0, 0, 0);
      vectors[18] = mkVec(AluOpMthi, AluSelNop,   32'hCAFE, 32'h0, 32'h0, 32'h77, 1, 32'h33, 32'h55, 0, 32'h0, 0, 1, 32'hCAFE, 32'h55);
      vectors[19] = mkVec(AluOpMtlo, AluSelNop,   32'hF00D, 32'h0, 32'h99, 32'h0, 0, 32'h44, 32'h66, 0, 32'h0, 0, 1, 32'h99, 32'hF00D);
      vectors[20] = mkVec(8'hFF,     AluSelLogic, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0, 0, 0, 1, 32'h0, 1, 0, 0, 0);
      vectors[21] = mkVec(AluOpNop,  AluSelNop,   32'h12345678, 32'h9ABCDEF0, 0, 0, 0, 0, 0, 1, 32'h0, 1, 0, 0, 0);

      opList = '{AluOpOr, AluOpAnd, AluOpXor, AluOpNor, AluOpSll, AluOpSrl, AluOpSra,
                 AluOpSlt, AluOpSltu, AluOpAdd, AluOpAddu, AluOpSub, AluOpSubu,
                 AluOpMult, AluOpMultu, AluOpMfhi, AluOpMflo, AluOpMthi, AluOpMtlo, 8'hEE};

      // Reset: outputs held at zero even with a live instruction on the inputs.
      rst = 1'b1;
      applyStimulus(vectors[0], 5'd9);
      repeat (2) @(negedge clk);
      checkOutput("reset wd",    64'(wd_o),    64'd0);
      checkOutput("reset wreg",  64'(wreg_o),  64'd0);
      checkOutput("reset wdata", 64'(wdata_o), 64'd0);
      checkOutput("reset whilo", 64'(whilo_o), 64'd0);
      checkOutput("reset hi",    64'(hi_o),    64'd0);
      checkOutput("reset lo",    64'(lo_o),    64'd0);
      aluop_i = AluOpDiv; alusel_i = AluSelNop; reg2_i = 32'd3;
      @(negedge clk);
      checkOutput("reset stall with div op", 64'(stallreq_from_ex), 64'd0);
      aluop_i = AluOpNop;
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 22; i++) runVector($sformatf("vec%0d", i), vectors[i]);

      for (int i = 0; i < 200; i++) begin
         v = refModel(opList[$urandom_range(0, 19)], pickOperand(), pickOperand(), $urandom,
                      $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom,
                      1'($urandom_range(0, 1)));
         runVector($sformatf("rand%0d op%0h", i, v.aluop), v);
      end

      runDivide("div -7/2", AluOpDiv, 32'hFFFFFFF9, 32'd2, 1'b0);
      runDivide("divu 7/0", AluOpDivu, 32'd7, 32'd0, 1'b0);
      runDivide("b2b first divu", AluOpDivu, 32'd1000, 32'd7, 1'b1);
      runDivide("b2b second div", AluOpDiv, 32'h80000000, 32'd3, 1'b0);
      runDivide("div 7/-2", AluOpDiv, 32'd7, 32'hFFFFFFFE, 1'b0);
      runDivide("div -5/0", AluOpDiv, 32'hFFFFFFFB, 32'd0, 1'b0);
      runDivide("divu max/1", AluOpDivu, 32'hFFFFFFFF, 32'd1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         runDivide($sformatf("rand div%0d", i), ($urandom_range(0, 1) == 1) ? AluOpDiv : AluOpDivu,
                   a, b, 1'b1);
      end

      // Reset in the middle of a divide aborts it with no HI/LO write afterwards.
      @(posedge clk); #1;
      aluop_i = AluOpDiv; alusel_i = AluSelNop; reg1_i = 32'd100; reg2_i = 32'd3;
      repeat (11) @(posedge clk);
      @(negedge clk);
      checkOutput("abort stall before reset", 64'(stallreq_from_ex), 64'd1);
      rst = 1'b1;
      aluop_i = AluOpNop;
      #1;
      checkOutput("abort stall in reset", 64'(stallreq_from_ex), 64'd0);
      checkOutput("abort whilo in reset", 64'(whilo_o), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      sawStall = 0; sawWhilo = 0;
      repeat (40) begin
         @(negedge clk);
         if (stallreq_from_ex) sawStall = 1;
         if (whilo_o) sawWhilo = 1;
      end
      checkOutput("abort stall after release", 64'(sawStall), 64'd0);
      checkOutput("abort whilo after release", 64'(sawWhilo), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
